// File: rtl/adpack_pkg.sv
// Shared widths, FSM encoding and chunk formatting for the capture packer and playback unpacker.
// No logic of its own; both sides import it so chunk layout and word order stay identical.
// Nothing here carries backpressure state.
package adpack_pkg;
  localparam int SAMPLE_W = 6;
  localparam int CHUNK_W  = 16;
  localparam int CHUNKS   = 8;
  localparam int WORD_W   = 128;
  localparam int IDX_W    = 3;
  localparam int PAD_W    = 2;

  typedef enum logic {S_EMPTY, S_PEND} state_t;

  // Places ad1 in [15:10] and ad2 in [7:2]; the two low bits of each byte are zero.
  function automatic logic [CHUNK_W-1:0] fmt_chunk(input logic [SAMPLE_W-1:0] a1,
                                                   input logic [SAMPLE_W-1:0] a2);
    return {a1, {PAD_W{1'b0}}, a2, {PAD_W{1'b0}}};
  endfunction
endpackage

// File: rtl/adpack_if.sv
// Sample-in / word-out bundle between the capture source, the packer and the word FIFO.
// master drives samples and the FIFO full flag; slave (the packer) drives the FIFO write side.
// full is the only backpressure signal and it is level-sensitive.
interface adpack_if;
  import adpack_pkg::*;

  logic [SAMPLE_W-1:0] ad1;
  logic [SAMPLE_W-1:0] ad2;
  logic                ad_valid;
  logic                full;
  logic                wr_en;
  logic [WORD_W-1:0]   dout;
  logic                overflow;

  modport master (output ad1, ad2, ad_valid, full,
                  input  wr_en, dout, overflow);
  modport slave  (input  ad1, ad2, ad_valid, full,
                  output wr_en, dout, overflow);
endinterface

// File: rtl/adpack.sv
// Packs 6-bit sample pairs into 16-bit chunks, eight per 128-bit word (first chunk in the MSBs).
// Latency: wr_en rises the cycle after the 8th sample edge; one pending word slot in front of the FIFO.
// Backpressure: full holds the pending word; a word completing while it is held is dropped (sticky overflow).
// Optional ADPACK_FLUSH_EN: an idle cycle with a partial word flushes it zero-padded in the low chunks.
module adpack
  import adpack_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  adpack_if.slave  bus
);

  logic [CHUNK_W-1:0] chunk;
  logic [WORD_W-1:0]  acc;
  logic [WORD_W-1:0]  shifted;
  logic [IDX_W-1:0]   index;
  logic               new_word;
  logic [WORD_W-1:0]  new_dat;
  state_t             state;
  state_t             state_nx;
  logic [WORD_W-1:0]  dout_q;
  logic [WORD_W-1:0]  dout_nx;
  logic               ovf_q;
  logic               ovf_nx;
  logic               wr;

  assign chunk   = fmt_chunk(bus.ad1, bus.ad2);
  assign shifted = {acc[WORD_W-CHUNK_W-1:0], chunk};

`ifdef ADPACK_FLUSH_EN
  // Chunks still missing from a partial word: (8 - index) mod 8, exact for index 1..7.
  logic [IDX_W-1:0] rem;
  logic [IDX_W+3:0] flush_sh;
  assign rem      = ~index + 1'b1;
  assign flush_sh = {rem, 4'b0000};
`endif

  // Word completion: 8th sample, or (flush build) an idle cycle with a partial word.
  always_comb begin
    new_word = 1'b0;
    new_dat  = shifted;
    if (bus.ad_valid && index == IDX_W'(CHUNKS - 1)) begin
      new_word = 1'b1;
    end
`ifdef ADPACK_FLUSH_EN
    else if (!bus.ad_valid && index != '0) begin
      new_word = 1'b1;
      new_dat  = acc << flush_sh;
    end
`endif
  end

  // Accumulator shifts chunks in from the bottom; a gap keeps the partial word unless flushing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc   <= '0;
      index <= '0;
    end else if (bus.ad_valid) begin
      acc   <= shifted;
      index <= index + 1'b1;
    end
`ifdef ADPACK_FLUSH_EN
    else if (index != '0) begin
      index <= '0;
    end
`endif
  end

  // A write needs a held word and room in the FIFO; never during reset.
  assign wr = (state == S_PEND) && !bus.full && !RST;

  // Pending-slot next state: load when empty or being written, otherwise drop and flag.
  always_comb begin
    state_nx = state;
    dout_nx  = dout_q;
    ovf_nx   = ovf_q;
    case (state)
      S_EMPTY: begin
        if (new_word) begin
          dout_nx  = new_dat;
          state_nx = S_PEND;
        end
      end
      S_PEND: begin
        if (wr) begin
          if (new_word) dout_nx  = new_dat;
          else          state_nx = S_EMPTY;
        end else if (new_word) begin
          ovf_nx = 1'b1;
        end
      end
      default: state_nx = S_EMPTY;
    endcase
  end

  // Pending-slot registers; overflow is sticky until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_EMPTY;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      dout_q <= dout_nx;
      ovf_q  <= ovf_nx;
    end
  end

  assign bus.wr_en    = wr;
  assign bus.dout     = dout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_adpack.sv
module tb_adpack;
  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errs;
  bit   chk_en;

  localparam logic [127:0] EXP1 = 128'h0020_0424_0828_0C2C_1030_1434_1838_1C3C;
  localparam logic [127:0] EXP2 = 128'h4060_4464_4868_4C6C_5070_5474_5878_5C7C;
  localparam logic [127:0] EXP3 = 128'h0408_0C10_1418_0000_0000_0000_0000_0000;

  adpack_if bus();

  adpack dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: list of chunks received so far plus one pending word.
  logic [15:0]  q[$];
  logic [127:0] m_dout;
  bit           m_pv;
  bit           m_ovf;

  function automatic logic [127:0] pack(input logic [15:0] c[$]);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < c.size(); k++) w[127 - 16*k -: 16] = c[k];
    return w;
  endfunction

  always @(posedge CLK) begin
    logic [127:0] w;
    bit nw;
    bit wr;
    if (RST) begin
      q.delete();
      m_pv   = 0;
      m_dout = '0;
      m_ovf  = 0;
    end else begin
      wr = m_pv && !bus.full;
      nw = 0;
      w  = '0;
      if (bus.ad_valid) begin
        q.push_back({bus.ad1, 2'b00, bus.ad2, 2'b00});
        if (q.size() == 8) begin
          nw = 1;
          w  = pack(q);
          q.delete();
        end
      end
`ifdef ADPACK_FLUSH_EN
      else if (q.size() != 0) begin
        nw = 1;
        w  = pack(q);
        q.delete();
      end
`endif
      if (nw) begin
        if (!m_pv || wr) begin
          m_dout = w;
          m_pv   = 1;
        end else begin
          m_ovf = 1;
        end
      end else if (wr) begin
        m_pv = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("wr_en", {127'b0, bus.wr_en}, {127'b0, (m_pv && !bus.full && !RST)});
      chk("dout", bus.dout, m_dout);
      chk("overflow", {127'b0, bus.overflow}, {127'b0, m_ovf});
    end
  end

  task automatic drv(input bit v, input logic [5:0] a1, input logic [5:0] a2, input bit f);
    @(posedge CLK);
    #1;
    RST          = 1'b0;
    bus.ad_valid = v;
    bus.ad1      = a1;
    bus.ad2      = a2;
    bus.full     = f;
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK);
    #1;
    RST          = 1'b1;
    bus.ad_valid = 1'b0;
    bus.full     = 1'b0;
    repeat (n - 1) @(posedge CLK);
    #1;
  endtask

  task automatic burst(input int base1, input int base2, input bit f);
    for (int i = 0; i < 8; i++) drv(1'b1, 6'(base1 + i), 6'(base2 + i), f);
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    chk_en   = 0;
    RST          = 1'b1;
    bus.ad_valid = 1'b0;
    bus.ad1      = '0;
    bus.ad2      = '0;
    bus.full     = 1'b0;
    @(posedge CLK);
    #1;
    chk_en = 1;
    @(posedge CLK);
    @(negedge CLK);
    chk("reset_wr_en", {127'b0, bus.wr_en}, 128'd0);
    chk("reset_dout", bus.dout, 128'd0);
    chk("reset_overflow", {127'b0, bus.overflow}, 128'd0);

    // Basic burst.
    burst(0, 8, 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("burst_wr_en", {127'b0, bus.wr_en}, 128'd1);
    chk("burst_dout", bus.dout, EXP1);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("burst_single_pulse", {127'b0, bus.wr_en}, 128'd0);

    // Same burst with a two-cycle gap after the 4th sample.
    for (int i = 0; i < 4; i++) drv(1'b1, 6'(i), 6'(i + 8), 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    for (int i = 4; i < 8; i++) drv(1'b1, 6'(i), 6'(i + 8), 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
`ifndef ADPACK_FLUSH_EN
    chk("gap_wr_en", {127'b0, bus.wr_en}, 128'd1);
    chk("gap_dout", bus.dout, EXP1);
`endif
    drv(1'b0, 0, 0, 1'b0);
    drv(1'b0, 0, 0, 1'b0);

    // full held over two completed words: second dropped.
    burst(0, 8, 1'b1);
    burst(16, 24, 1'b1);
    drv(1'b0, 0, 0, 1'b1);
    @(negedge CLK);
    chk("hold_overflow", {127'b0, bus.overflow}, 128'd1);
    chk("hold_dout", bus.dout, EXP1);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("hold_release_wr", {127'b0, bus.wr_en}, 128'd1);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("hold_one_write", {127'b0, bus.wr_en}, 128'd0);

    // full released on the very cycle the next word completes.
    do_reset(2);
    burst(0, 8, 1'b1);
    for (int i = 0; i < 7; i++) drv(1'b1, 6'(16 + i), 6'(24 + i), 1'b1);
    drv(1'b1, 6'd23, 6'd31, 1'b0);
    @(negedge CLK);
    chk("swap_wr_old", {127'b0, bus.wr_en}, 128'd1);
    chk("swap_dout_old", bus.dout, EXP1);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("swap_wr_new", {127'b0, bus.wr_en}, 128'd1);
    chk("swap_dout_new", bus.dout, EXP2);
    chk("swap_no_overflow", {127'b0, bus.overflow}, 128'd0);
    drv(1'b0, 0, 0, 1'b0);

`ifdef ADPACK_FLUSH_EN
    // Partial word flushed on an idle cycle.
    do_reset(2);
    drv(1'b1, 6'd1, 6'd2, 1'b0);
    drv(1'b1, 6'd3, 6'd4, 1'b0);
    drv(1'b1, 6'd5, 6'd6, 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("flush_wr_en", {127'b0, bus.wr_en}, 128'd1);
    chk("flush_dout", bus.dout, EXP3);
    drv(1'b0, 0, 0, 1'b0);
`endif

    // Reset in the middle of a word.
    burst(0, 8, 1'b1);
    for (int i = 0; i < 5; i++) drv(1'b1, 6'(40 + i), 6'(50 + i), 1'b0);
    do_reset(1);
    burst(0, 8, 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    chk("rst_fresh_wr", {127'b0, bus.wr_en}, 128'd1);
    chk("rst_fresh_dout", bus.dout, EXP1);
    chk("rst_overflow", {127'b0, bus.overflow}, 128'd0);

    // Randomized traffic with bursts of full and rare resets.
    begin
      bit f;
      f = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 5) == 0) f = ~f;
        if ($urandom_range(0, 799) == 0) begin
          do_reset(1);
        end else begin
          drv($urandom_range(0, 9) < 7, 6'($urandom), 6'($urandom), f);
        end
      end
    end
    drv(1'b0, 0, 0, 1'b0);
    drv(1'b0, 0, 0, 1'b0);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
